// File: rtl/down_counter_timer.sv
// Loadable countdown timer: one-cycle io_zero at terminal count, io_done after.
// Define DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload at terminal count.
module down_counter_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic             io_start,
  input  logic             io_stop,
  input  logic [WIDTH-1:0] io_load_val,
  output logic [WIDTH-1:0] io_count,
  output logic             io_zero,
  output logic             io_busy,
  output logic             io_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    zero_d   = 1'b0;
    load     = 1'b0;

    unique case (state_q)
      IDLE, DONE: load = io_start;
      RUN: begin
        if (io_stop) begin
          state_d = PAUSE;
        end else if (io_start) begin
          load = 1'b1;
        end else if (io_en && count_q == ONE) begin
          zero_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          count_d = reload_q;
`else
          count_d = '0;
          state_d = DONE;
`endif
        end else if (io_en && count_q != '0) begin
          count_d = count_q - ONE;
        end
      end
      PAUSE: begin
        if (io_start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    // A zero load terminates immediately instead of entering RUN.
    if (load) begin
      count_d  = io_load_val;
      reload_d = io_load_val;
      if (io_load_val == '0) begin
        state_d = DONE;
        zero_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign io_count = count_q;
  assign io_zero  = zero_q;
  assign io_busy  = busy_q;
  assign io_done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed plus random checks of down_counter_timer against a behavioural model.
module tb_down_counter_timer;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         io_en = 1'b0;
  logic         io_start = 1'b0;
  logic         io_stop = 1'b0;
  logic [W-1:0] io_load_val = '0;
  logic [W-1:0] io_count;
  logic         io_zero, io_busy, io_done;

  int tests = 0;
  int fails = 0;

  // Model: mode 0 idle, 1 running, 2 paused, 3 finished.
  int           m_mode = 0;
  logic [W-1:0] m_count = '0;
  logic [W-1:0] m_reload = '0;
  bit           m_zero = 0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .io_en(io_en),
    .io_start(io_start), .io_stop(io_stop),
    .io_load_val(io_load_val), .io_count(io_count),
    .io_zero(io_zero), .io_busy(io_busy), .io_done(io_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_update();
    m_zero = 0;
    if (reset) begin
      m_mode = 0; m_count = '0; m_reload = '0;
    end else if (m_mode == 1 && io_stop) begin
      m_mode = 2;
    end else if (io_start && m_mode == 2) begin
      m_mode = 1;
    end else if (io_start) begin
      m_count  = io_load_val;
      m_reload = io_load_val;
      m_zero   = (io_load_val == 0);
      m_mode   = m_zero ? 3 : 1;
    end else if (m_mode == 1 && io_en && m_count != 0) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_zero = 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        m_count = m_reload;
`else
        m_mode = 3;
`endif
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit p,
                      input bit e, input logic [W-1:0] l);
    reset = r; io_start = s; io_stop = p; io_en = e; io_load_val = l;
    model_update();
    @(posedge clock);
    #1;
    chk("count", io_count, m_count);
    chk("zero", W'(io_zero), W'(m_zero));
    chk("busy", W'(io_busy), W'(m_mode == 1 || m_mode == 2));
    chk("done", W'(io_done), W'(m_mode == 3));
  endtask

  initial begin
    int cyc;
    int zc;
    bit seen;

    step(1, 0, 0, 0, '0);
    step(1, 1, 0, 1, 7);
    chk("rst_count", io_count, '0);
    chk("rst_flags", W'({io_zero, io_busy, io_done}), '0);

    // Load 5, continuous ticks: 5,4,3,2,1,0.
    step(0, 1, 0, 1, 5);
    chk("load5", io_count, 5);
    for (int i = 4; i >= 0; i--) begin
      step(0, 0, 0, 1, 0);
      chk("seq5", io_count, W'(i));
    end
    chk("seq5_end", W'({io_zero, io_busy, io_done}), W'(3'b101));
    step(0, 0, 0, 1, 0);
    chk("zero_once", W'(io_zero), '0);

    // Load 10, strobe every third cycle.
    step(0, 1, 0, 0, 10);
    cyc = 0;
    seen = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      step(0, 0, 0, (i % 3) == 0, 0);
      cyc = i;
      seen = io_zero;
    end
    chk("strobe_seen", W'(seen), 1);
    chk("strobe_cyc", W'(cyc), 30);

    // Pause with simultaneous tick, resume ignores load value.
    step(0, 1, 0, 0, 8);
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("pause5", io_count, 5);
    repeat (4) step(0, 0, 0, 1, 0);
    chk("pause_hold", io_count, 5);
    step(0, 1, 0, 0, 99);
    chk("resume5", io_count, 5);
    repeat (5) step(0, 0, 0, 1, 0);
    chk("resume_end", W'({io_zero, io_done}), W'(2'b11));

    // Zero load.
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("load0", W'({io_zero, io_busy, io_done}), W'(3'b101));
    step(0, 0, 0, 0, 0);

    // Full scale then reset mid-run.
    step(0, 1, 0, 0, '1);
    repeat (2) step(0, 0, 0, 1, 0);
    chk("full_m2", io_count, W'(32'hFFFF_FFFD));
    step(1, 0, 0, 1, 0);
    chk("rst_mid", W'({io_count, io_zero, io_busy, io_done}), '0);

    // Reload-mode periodic check (one-shot ends after first period).
    step(0, 1, 0, 0, 3);
    zc = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1, 0);
      zc += io_zero;
    end
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    chk("reload_pulses", W'(zc), 4);
`else
    chk("oneshot_pulses", W'(zc), 1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
           W'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
